// File: rtl/otter_mmio_pkg.sv
// Shared address map and range limits for the OTTER MMIO hub.
// Interrupt logic in the hub is built only when OTTER_MMIO_IRQ_EN is defined.
package otter_mmio_pkg;

   localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
   localparam logic [31:0] BTN_AD      = 32'h1104_0000;
   localparam logic [31:0] OUT_BASE_AD = 32'h1108_0000;
   localparam logic [31:0] OUT_STRIDE  = 32'h0004_0000;
   localparam logic [31:0] IRQ_STAT_AD = 32'h1120_0000;
   localparam logic [31:0] IRQ_MASK_AD = 32'h1124_0000;

   localparam int MAX_NUM_OUT = 8;
   localparam int MAX_NUM_BTN = 8;

   function automatic logic [31:0] out_ad(input int unsigned idx);
      return OUT_BASE_AD + (OUT_STRIDE * 32'(idx));
   endfunction

endpackage

// File: rtl/otter_btn_debounce.sv
// One button: 2-flop synchronizer, saturating debounce counter and
// a single-cycle press pulse on each accepted 0->1 transition.
module otter_btn_debounce #(
   parameter int DB_CYCLES = 20000
)(
   input  logic CLK,
   input  logic RST_N,
   input  logic btn_i,
   output logic db_o,
   output logic press_o
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             meta_q, sync_q;
   logic             db_q, db_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive disagreements; the last one flips the level and clears the count.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_q == db_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = {CNT_W{1'b0}};
         db_d  = ~db_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      press_d = db_d & ~db_q;
   end

   // Synchronizer, debounce state and press pulse registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         db_q    <= db_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o    = db_q;
   assign press_o = press_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// OTTER MMIO hub: switches, debounced buttons, output registers and
// button interrupts (interrupts present only with OTTER_MMIO_IRQ_EN defined).
module otter_mmio_hub
   import otter_mmio_pkg::*;
#(
   parameter int NUM_OUT   = 2,
   parameter int SW_W      = 16,
   parameter int NUM_BTN   = 4,
   parameter int DB_CYCLES = 20000
)(
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [31:0]              IOBUS_ADDR,
   input  logic [31:0]              IOBUS_OUT,
   input  logic                     IOBUS_WR,
   output logic [31:0]              IOBUS_IN,
   input  logic [SW_W-1:0]          SWITCHES,
   input  logic [NUM_BTN-1:0]       BTNS,
   output logic [NUM_OUT-1:0][31:0] OUT_REGS,
   output logic [NUM_BTN-1:0]       BTN_DB,
   output logic                     INTR
);

   logic [SW_W-1:0]          sw_meta_q, sw_sync_q;
   logic [NUM_OUT-1:0][31:0] out_q, out_d;
   logic [NUM_BTN-1:0]       press_s, db_s, stat_rd_s, mask_rd_s;
   logic [31:0]              out_rd_s, rd_s;

   // Switch synchronizer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sw_meta_q <= {SW_W{1'b0}};
         sw_sync_q <= {SW_W{1'b0}};
      end else begin
         sw_meta_q <= SWITCHES;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Output register write decode.
   always_comb begin
      out_d = out_q;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (IOBUS_WR && (IOBUS_ADDR == out_ad(i))) begin
            out_d[i] = IOBUS_OUT;
         end else begin
            out_d[i] = out_q[i];
         end
      end
   end

   // Output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_q <= '{default: 32'h0};
      end else begin
         out_q <= out_d;
      end
   end

   for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
      otter_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .btn_i   (BTNS[k]),
         .db_o    (db_s[k]),
         .press_o (press_s[k])
      );
   end

`ifdef OTTER_MMIO_IRQ_EN
   logic [NUM_BTN-1:0] stat_q, stat_d, mask_q, mask_d;
   logic               intr_q, intr_d;

   // Press sets are OR-ed in after the W1C clear so a coincident press wins.
   always_comb begin
      if (IOBUS_WR && (IOBUS_ADDR == IRQ_STAT_AD)) begin
         stat_d = (stat_q & ~IOBUS_OUT[NUM_BTN-1:0]) | press_s;
      end else begin
         stat_d = stat_q | press_s;
      end
      if (IOBUS_WR && (IOBUS_ADDR == IRQ_MASK_AD)) begin
         mask_d = IOBUS_OUT[NUM_BTN-1:0];
      end else begin
         mask_d = mask_q;
      end
      intr_d = |(stat_q & mask_q);
   end

   // Interrupt status, mask and request registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stat_q <= {NUM_BTN{1'b0}};
         mask_q <= {NUM_BTN{1'b0}};
         intr_q <= 1'b0;
      end else begin
         stat_q <= stat_d;
         mask_q <= mask_d;
         intr_q <= intr_d;
      end
   end

   assign stat_rd_s = stat_q;
   assign mask_rd_s = mask_q;
   assign INTR      = intr_q;
`else
   logic unused_press_s;

   assign unused_press_s = ^press_s;
   assign stat_rd_s      = {NUM_BTN{1'b0}};
   assign mask_rd_s      = {NUM_BTN{1'b0}};
   assign INTR           = 1'b0;
`endif

   // Read mux; every unmatched address falls through to zero.
   always_comb begin
      out_rd_s = 32'h0;
      for (int i = 0; i < NUM_OUT; i++) begin
         out_rd_s = out_rd_s | ((IOBUS_ADDR == out_ad(i)) ? out_q[i] : 32'h0);
      end
      if (IOBUS_ADDR == SWITCHES_AD) begin
         rd_s = 32'(sw_sync_q);
      end else if (IOBUS_ADDR == BTN_AD) begin
         rd_s = 32'(db_s);
      end else if (IOBUS_ADDR == IRQ_STAT_AD) begin
         rd_s = 32'(stat_rd_s);
      end else if (IOBUS_ADDR == IRQ_MASK_AD) begin
         rd_s = 32'(mask_rd_s);
      end else begin
         rd_s = out_rd_s;
      end
   end

   assign IOBUS_IN = rd_s;
   assign OUT_REGS = out_q;
   assign BTN_DB   = db_s;

endmodule

// File: doc/otter_mmio_hub.md
OTTER_MMIO_HUB -- requirements
Module: otter_mmio_hub

Interface
REQ-001 SHALL have parameter NUM_OUT, default 2, the number of 32-bit output registers (legal range 1..8).
REQ-002 SHALL have parameter SW_W, default 16, the switch input width (legal range 1..32).
REQ-003 SHALL have parameter NUM_BTN, default 4, the number of debounced button inputs (legal range 1..8).
REQ-004 SHALL have parameter DB_CYCLES, default 20000, the stable-cycle count required to accept a button change (minimum 2).
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port IOBUS_ADDR  input  32  CPU MMIO address.
REQ-008 SHALL have port IOBUS_OUT  input  32  CPU write data.
REQ-009 SHALL have port IOBUS_WR  input  1  write strobe, one cycle per store.
REQ-010 SHALL have port IOBUS_IN  output  32  read data to CPU, combinational from IOBUS_ADDR.
REQ-011 SHALL have port SWITCHES  input  SW_W  asynchronous board switches.
REQ-012 SHALL have port BTNS  input  NUM_BTN  asynchronous, bouncing board buttons.
REQ-013 SHALL have port OUT_REGS  output  NUM_OUT x 32  output register contents (index 0 = LEDs, 1 = seven-segment).
REQ-014 SHALL have port BTN_DB  output  NUM_BTN  debounced button levels.
REQ-015 SHALL have port INTR  output  1  registered interrupt request to the MCU.

Function
REQ-016 Address map SHALL be: SWITCHES_AD 0x11000000 (RO), BTN_AD 0x11040000 (RO), OUT_AD(i) = 0x11080000 + i*0x40000 (RW), IRQ_STAT_AD 0x11200000 (RW1C), IRQ_MASK_AD 0x11240000 (RW).
REQ-017 Address decode SHALL be an exact 32-bit match; unmapped reads return 0; writes to unmapped or RO addresses are ignored.
REQ-018 A write to OUT_AD(i) SHALL update OUT_REGS[i] on the same rising edge where IOBUS_WR=1; readback returns the current register value.
REQ-019 SWITCHES SHALL pass through a 2-flop synchronizer; a SWITCHES read returns the synchronized value zero-extended, i.e. 2-cycle latency.
REQ-020 Each button SHALL be 2-flop synchronized and then debounced: BTN_DB[k] toggles only after the synchronized input differs from BTN_DB[k] for DB_CYCLES consecutive cycles; any intervening match restarts the count at 0.
REQ-021 Each 0->1 transition of BTN_DB[k] SHALL produce exactly one single-cycle press pulse; 1->0 transitions produce none.
REQ-022 The debounce counter width SHALL be $clog2(DB_CYCLES+1) and the counter SHALL never wrap.
REQ-023 A press pulse SHALL set IRQ_STAT[k]; writing 1 to a bit clears it; writing 0 leaves it unchanged.
REQ-024 When a press pulse and a W1C write hit the same bit in the same cycle, the set SHALL win.
REQ-025 INTR SHALL be registered as |(IRQ_STAT & IRQ_MASK), one cycle after the contributing state changes.
REQ-026 IRQ_STAT and IRQ_MASK SHALL be NUM_BTN bits wide; upper read bits return 0 and upper written bits are ignored.

Reset
REQ-027 While RST_N=0, the block SHALL asynchronously clear OUT_REGS, synchronizers, debounce counters, BTN_DB, IRQ_STAT, IRQ_MASK and INTR to 0.
REQ-028 Reset assertion mid-debounce SHALL discard the count, and deassertion SHALL NOT generate a press pulse.

Configuration
REQ-029 With macro OTTER_MMIO_IRQ_EN defined, the block SHALL implement IRQ_STAT, IRQ_MASK and INTR as specified.
REQ-030 Without OTTER_MMIO_IRQ_EN, no interrupt flops SHALL exist: INTR is tied to 0, IRQ addresses read 0 and ignore writes, and debounce and BTN_AD behaviour is unchanged.

Structure
REQ-031 Package otter_mmio_pkg SHALL hold all address constants, the OUT_STRIDE constant (0x40000) and the max-range constants for NUM_OUT and NUM_BTN.
REQ-032 Per-button synchronize, debounce and edge detection SHALL be sub-module otter_btn_debounce, instantiated NUM_BTN times via generate.

Verification (DB_CYCLES=4 in bench)
REQ-033 Write 0x0000ABCD to 0x11080000 and 0x00001234 to 0x110C0000 -> OUT_REGS[0]=0xABCD and OUT_REGS[1]=0x1234 next edge; reads return the same values; read of 0x11100000 returns 0.
REQ-034 SWITCHES=0x5A5A at cycle n -> a SWITCHES_AD read returns 0x00005A5A from cycle n+2, old value before.
REQ-035 BTNS[1] bounces 1,0,1 for 1 cycle each then holds 1 -> a single rise of BTN_DB[1] after 4 stable synchronized cycles, with IRQ_STAT=0x2.
REQ-036 With IRQ_MASK=0x2 and a press on button 1 -> INTR=1 one cycle after IRQ_STAT sets; write 0x2 to IRQ_STAT_AD -> STAT=0, then INTR=0 next cycle.
REQ-037 Press pulse on bit 0 coincides with a W1C write of 0x1 -> IRQ_STAT[0] stays 1.
REQ-038 Assert RST_N=0 with BTN_DB=1 and OUT_REGS[0]=0xFF -> all outputs 0 immediately without a clock; after release with BTNS still 1 -> re-debounce and one new press pulse; build without OTTER_MMIO_IRQ_EN -> INTR stays 0 throughout.
